// File: rtl/swar_playback_ctrl_if.sv
// Swar memory bus: controller drives address and swar select, memory returns
// combinational sample data.
interface swar_playback_ctrl_if;
  logic [12:0] mem_addr;
  logic [2:0]  mem_sel;
  logic [7:0]  mem_data;

  modport master (output mem_addr, output mem_sel, input mem_data);
  modport slave  (input mem_addr, input mem_sel, output mem_data);
endinterface

// File: rtl/swar_playback_ctrl.sv
// Live playback sequencer for the harmonica swar ROM. Define SWAR_LOOP_EN to loop
// a held note seamlessly; the default build plays each note once, then holds silence.
module swar_playback_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SAMPLE_HZ = 8000,
  parameter int SAMPLES   = 8000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [6:0]                  key,
  swar_playback_ctrl_if.master        mem,
  output logic [7:0]                  sample_out,
  output logic                        sample_valid,
  output logic                        busy
);

  localparam int          DIV       = CLK_HZ / SAMPLE_HZ;
  localparam int          CNT_W     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [12:0] LAST_ADDR = 13'(SAMPLES - 1);
  localparam logic [7:0]  SILENCE   = 8'h80;
  localparam logic [2:0]  NO_SWAR   = 3'b111;

  typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

  state_t             state_q, state_d;
  logic [6:0]         key_meta_q, key_meta_d;
  logic [6:0]         ks_q, ks_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [12:0]        mem_addr_q, mem_addr_d;
  logic [2:0]         mem_sel_q, mem_sel_d;
  logic [2:0]         note_q, note_d;
  logic [7:0]         sample_out_q, sample_out_d;
  logic               sample_valid_q, sample_valid_d;
  logic               busy_q, busy_d;

  logic [7:0]         ks_ext;
  logic               note_held;
  logic               tick;

  function automatic logic [2:0] lowest_set(input logic [6:0] v);
    lowest_set = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  // note_q is kept after mem_sel is cleared so HOLD can still watch the key
  assign ks_ext    = {1'b0, ks_q};
  assign note_held = ks_ext[note_q];
  assign tick      = (state_q == PLAY) && (count_q == CNT_W'(DIV - 1));

  always_comb begin
    state_d        = state_q;
    key_meta_d     = key;
    ks_d           = key_meta_q;
    count_d        = '0;
    mem_addr_d     = mem_addr_q;
    mem_sel_d      = mem_sel_q;
    note_d         = note_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    busy_d         = busy_q;

    if (state_q == PLAY) count_d = tick ? '0 : count_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (ks_q != 7'd0) begin
          state_d    = PLAY;
          note_d     = lowest_set(ks_q);
          mem_sel_d  = lowest_set(ks_q);
          mem_addr_d = 13'd0;
          busy_d     = 1'b1;
        end
      end
      PLAY: begin
        if (tick) begin
          if (!note_held) begin
            state_d      = IDLE;
            sample_out_d = SILENCE;
            mem_sel_d    = NO_SWAR;
            mem_addr_d   = 13'd0;
            busy_d       = 1'b0;
          end else begin
            sample_out_d   = mem.mem_data;
            sample_valid_d = 1'b1;
            if (mem_addr_q < LAST_ADDR) begin
              mem_addr_d = mem_addr_q + 13'd1;
            end else begin
`ifdef SWAR_LOOP_EN
              mem_addr_d = 13'd0;
`else
              state_d    = HOLD;
`endif
            end
          end
        end
      end
      HOLD: begin
        sample_out_d = SILENCE;
        mem_sel_d    = NO_SWAR;
        if (!note_held) begin
          state_d    = IDLE;
          mem_addr_d = 13'd0;
          busy_d     = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        sample_out_d = SILENCE;
        mem_sel_d    = NO_SWAR;
        mem_addr_d   = 13'd0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      key_meta_q     <= '0;
      ks_q           <= '0;
      count_q        <= '0;
      mem_addr_q     <= 13'd0;
      mem_sel_q      <= NO_SWAR;
      note_q         <= NO_SWAR;
      sample_out_q   <= SILENCE;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_meta_q     <= key_meta_d;
      ks_q           <= ks_d;
      count_q        <= count_d;
      mem_addr_q     <= mem_addr_d;
      mem_sel_q      <= mem_sel_d;
      note_q         <= note_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_sel  = mem_sel_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_swar_playback_ctrl.sv
// Randomized bench for swar_playback_ctrl against a note-level reference model;
// DIV=16, SAMPLES=4, memory returns {sel, addr[4:0]}.
module tb_swar_playback_ctrl;

  localparam int DIV     = 16;
  localparam int SAMPLES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] key = 7'd0;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       busy;

  swar_playback_ctrl_if memBus ();

  assign memBus.mem_data = {memBus.mem_sel, memBus.mem_addr[4:0]};

  swar_playback_ctrl #(
    .CLK_HZ   (16),
    .SAMPLE_HZ(1),
    .SAMPLES  (SAMPLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .mem         (memBus),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;
  int pulseCount  = 0;

  // Reference model: mode 0 idle, 1 playing, 2 holding after a one-shot note
  int         mode = 0;
  int         note = 7;
  int         age = 0;
  int         idx = 0;
  int         lowBit;
  logic [6:0] sync1 = 7'd0;
  logic [6:0] sync2 = 7'd0;
  logic [6:0] seen;
  logic [7:0] expOut = 8'h80;
  logic [2:0] expSel = 3'h7;
  logic [12:0] expAddr = 13'd0;
  logic       expValid = 1'b0;
  logic       expBusy = 1'b0;

  task automatic stopNote();
    mode    = 0;
    idx     = 0;
    expOut  = 8'h80;
    expSel  = 3'h7;
    expAddr = 13'd0;
    expBusy = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 = 7'd0;
      sync2 = 7'd0;
      mode  = 0;
      note  = 7;
      age   = 0;
      stopNote();
      expValid = 1'b0;
    end else begin
      seen     = sync2;
      sync2    = sync1;
      sync1    = key;
      expValid = 1'b0;
      if (mode == 0) begin
        if (seen != 7'd0) begin
          lowBit = int'(seen) & -int'(seen);
          note   = 0;
          while (lowBit > 1) begin
            lowBit = lowBit >> 1;
            note++;
          end
          mode    = 1;
          age     = 0;
          idx     = 0;
          expSel  = 3'(note);
          expAddr = 13'd0;
          expBusy = 1'b1;
        end
      end else if (mode == 1) begin
        if (age % DIV == DIV - 1) begin
          if (!seen[note]) begin
            stopNote();
          end else begin
            expOut   = 8'((note << 5) | (idx % 32));
            expValid = 1'b1;
            if (idx == SAMPLES - 1) begin
`ifdef SWAR_LOOP_EN
              idx = 0;
`else
              mode = 2;
`endif
            end else begin
              idx++;
            end
            expAddr = 13'(idx);
          end
        end
        age++;
      end else begin
        expOut = 8'h80;
        expSel = 3'h7;
        if (!seen[note]) stopNote();
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectorCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("mem_sel", 32'(memBus.mem_sel), 32'(expSel));
    checkOutput("sample_out", 32'(sample_out), 32'(expOut));
    checkOutput("sample_valid", 32'(sample_valid), 32'(expValid));
    if (mode != 2) checkOutput("mem_addr", 32'(memBus.mem_addr), 32'(expAddr));
    if (sample_valid === 1'b1) pulseCount++;
  endtask

  task automatic applyStimulus(input logic [6:0] keyVal, input int cycles);
    key = keyVal;
    repeat (cycles) begin
      @(negedge clk);
      checkAll();
    end
  endtask

  // Reset is asserted between edges; outputs must clear without waiting for a clock
  task automatic pulseReset(input int lowCycles);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_addr", 32'(memBus.mem_addr), 32'd0);
    checkOutput("rst_sel", 32'(memBus.mem_sel), 32'h7);
    checkOutput("rst_out", 32'(sample_out), 32'h80);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    repeat (lowCycles) begin
      @(negedge clk);
      checkAll();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int         pick;
    logic [6:0] randKey;

    #1;
    pulseReset(3);

    applyStimulus(7'b0000100, 80);
    applyStimulus(7'b0000000, 40);

    pulseCount = 0;
    applyStimulus(7'b0000100, 200);
`ifdef SWAR_LOOP_EN
    checkOutput("pulse_count", 32'(pulseCount), 32'd12);
`else
    checkOutput("pulse_count", 32'(pulseCount), 32'd4);
`endif
    applyStimulus(7'b0000000, 40);

    applyStimulus(7'b0101000, 40);
    applyStimulus(7'b0100000, 60);
    applyStimulus(7'b0000000, 40);

    applyStimulus(7'b0000100, 30);
    pulseReset(2);
    applyStimulus(7'b0000100, 40);
    applyStimulus(7'b0000000, 40);

    for (int n = 0; n < 80; n++) begin
      pick = int'($urandom_range(0, 3));
      if (pick == 0)      randKey = 7'd0;
      else if (pick == 1) randKey = 7'(1 << $urandom_range(0, 6));
      else                randKey = 7'($urandom);
      applyStimulus(randKey, int'($urandom_range(1, 70)));
      if ($urandom_range(0, 19) == 0) pulseReset(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
